muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring divide feeding HiLo.
// Optional MULDIV_ACCUM_EN adds MADD/MADDU (product accumulated onto HiLoRead).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
`ifdef MULDIV_ACCUM_EN
    input  logic [2:0]           Op,
`else
    input  logic [1:0]           Op,
`endif
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2*WIDTH-1:0]   HiLoRead,
    output logic                 Busy,
    output logic                 Done,
    output logic                 HiLoEn,
    output logic [2*WIDTH-1:0]   HiLoWrite
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    state_e state_q, state_d;

    logic [2:0]           op3;
    logic                 op_div, op_signed, op_ok, accept, div_zero;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_q, hilo_q, mult_next, div_next, prod_fix, result;
    logic [WIDTH-1:0]     opnd_q, quot_fix, rem_fix;
    logic [WIDTH:0]       mult_sum, div_hi, div_diff;
    logic [CW-1:0]        count_q;
    logic                 is_div_q, neg_res_q, neg_rem_q, div_zero_q, done_q;
`ifdef MULDIV_ACCUM_EN
    logic                 accum_q;
    logic [2*WIDTH-1:0]   base_q;
`else
    logic                 unused_hilo;
    assign unused_hilo = ^HiLoRead;
`endif

    // Operation decode and operand magnitudes
    always_comb begin
        op3       = 3'(Op);
        op_div    = (op3 == 3'd2) || (op3 == 3'd3);
        op_signed = (op3 == 3'd0) || (op3 == 3'd2) || (op3 == 3'd4);
`ifdef MULDIV_ACCUM_EN
        op_ok     = (op3 <= 3'd5);
`else
        op_ok     = 1'b1;
`endif
        div_zero  = op_div && (B == '0);
        accept    = (state_q == StIdle) && Start && op_ok;
        a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;
    end

    // One iteration step; acc holds {product hi, multiplier} or {remainder, quotient}
    always_comb begin
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mult_next = {mult_sum, acc_q[WIDTH-1:1]};
        div_hi    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_hi - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (div_zero_q) begin
            result = acc_q;
        end else if (is_div_q) begin
            result = {rem_fix, quot_fix};
        end else begin
            result = prod_fix;
        end
`ifdef MULDIV_ACCUM_EN
        if (accum_q) begin
            result = base_q + prod_fix;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = div_zero ? StDone : StRun;
                end
            end
            StRun: begin
                Busy = 1'b1;
                if (count_q == LAST) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hilo_q     <= '0;
`ifdef MULDIV_ACCUM_EN
            accum_q    <= 1'b0;
            base_q     <= '0;
`endif
        end else begin
            done_q <= (state_q == StDone);
            if (state_q == StDone) begin
                hilo_q <= result;
            end
            if (accept) begin
                count_q    <= '0;
                is_div_q   <= op_div;
                div_zero_q <= div_zero;
                neg_res_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_rem_q  <= op_signed && A[WIDTH-1];
                // Multiply: acc low = multiplier, opnd = multiplicand; divide: dividend / divisor
                if (div_zero) begin
                    acc_q <= {A, {WIDTH{1'b1}}};
                end else if (op_div) begin
                    acc_q <= {{WIDTH{1'b0}}, a_mag};
                end else begin
                    acc_q <= {{WIDTH{1'b0}}, b_mag};
                end
                opnd_q <= op_div ? b_mag : a_mag;
`ifdef MULDIV_ACCUM_EN
                accum_q <= (op3 == 3'd4) || (op3 == 3'd5);
                base_q  <= HiLoRead;
`endif
            end else if (state_q == StRun) begin
                acc_q   <= is_div_q ? div_next : mult_next;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign Done      = done_q;
    assign HiLoEn    = done_q;
    assign HiLoWrite = hilo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HiLo values queued at Start, checked on HiLoEn.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_ACCUM_EN
    localparam int OPW = 3;
`else
    localparam int OPW = 2;
`endif

    logic           Clk = 1'b0;
    logic           Rst, Start;
    logic [OPW-1:0] Op;
    logic [W-1:0]   A, B;
    logic [63:0]    HiLoRead, HiLoWrite;
    logic           Busy, Done, HiLoEn;

    int          errs = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .HiLoRead(HiLoRead),
        .Busy(Busy), .Done(Done), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst && (Done || HiLoEn)) begin
            check_val("done_eq_en", 64'(Done), 64'(HiLoEn));
            check_val("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_val("hilo", HiLoWrite, exp_q.pop_front());
            done_cnt++;
        end
    end

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] base);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = ua * ub;
            3'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            3'd4: p = base + 64'(sa * sb);
            default: p = base + ua * ub;
        endcase
        return p;
    endfunction

    // Called at a negedge; Start is sampled by the next posedge (edge 0)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hr, input logic [63:0] exp, input int lat,
                          input bit inject);
        int idx;
        int busy_n;
        logic seen;
        logic [2:0] opv;
        opv = op;
        Op = opv[OPW-1:0];
        A = a;
        B = b;
        HiLoRead = hr;
        Start = 1'b1;
        exp_q.push_back(exp);
        busy_n = 0;
        seen = 1'b0;
        for (idx = 0; idx < 100; idx++) begin
            @(negedge Clk);
            if (idx == 0) begin
                Start = 1'b0;
                A = ~a;
                B = ~b;
                HiLoRead = ~hr;
            end
            if (inject && idx == 4) begin
                Start = 1'b1;
                A = 32'd99;
                B = 32'd3;
            end
            if (inject && idx == 5) Start = 1'b0;
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_n++;
        end
        check_val("done_seen", 64'(seen), 64'd1);
        check_val("latency", 64'(idx), 64'(lat));
        check_val("busy_cycles", 64'(busy_n), (lat == 1) ? 64'd0 : 64'd32);
        @(negedge Clk);
        check_val("done_pulse", 64'(Done), 64'd0);
        check_val("hold", HiLoWrite, exp);
    endtask

    initial begin
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        Rst = 1'b1;
        Start = 1'b0;
        Op = '0;
        A = '0;
        B = '0;
        HiLoRead = '0;
        repeat (2) @(negedge Clk);
        check_val("rst_busy", 64'(Busy), 64'd0);
        check_val("rst_done", 64'(Done), 64'd0);
        check_val("rst_en", 64'(HiLoEn), 64'd0);
        check_val("rst_hilo", HiLoWrite, 64'd0);
        Rst = 1'b0;
        @(negedge Clk);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 33, 1'b0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 33, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        run_op(3'd3, 32'd100, 32'd0, 64'd0, 64'h0000_0064_FFFF_FFFF, 1, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 33, 1'b0);

        n = done_cnt;
        run_op(3'd3, 32'd50, 32'd7, 64'd0, 64'h0000_0001_0000_0007, 33, 1'b1);
        repeat (40) @(negedge Clk);
        check_val("no_second_done", 64'(done_cnt), 64'(n + 1));

        // Abort a multiply with reset mid-run
        Op = 'd1;
        A = 32'd6;
        B = 32'd7;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_val("abort_busy", 64'(Busy), 64'd0);
        check_val("abort_hilo", HiLoWrite, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        n = done_cnt;
        repeat (40) @(negedge Clk);
        check_val("abort_no_en", 64'(done_cnt), 64'(n));
        run_op(3'd1, 32'd6, 32'd7, 64'd0, 64'h0000_0000_0000_002A, 33, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 1) b = 32'($urandom_range(1, 20));
            run_op(op, a, b, 64'd0, model(op, a, b, 64'd0),
                   (op >= 3'd2 && b == 0) ? 1 : 33, 1'b0);
        end

`ifdef MULDIV_ACCUM_EN
        run_op(3'd5, 32'd3, 32'd4, 64'h10, 64'h0000_0000_0000_001C, 33, 1'b0);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
        n = done_cnt;
        Op = 3'd6;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check_val("op6_busy", 64'(Busy), 64'd0);
        repeat (40) @(negedge Clk);
        check_val("op6_ignored", 64'(done_cnt), 64'(n));
`endif

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
